// File: rtl/avr_port_arbiter_if.sv
// ============================================================================
// avr_port_arbiter_if
// Requester-side bundle of the AVR port arbiter: level requests, per-requester
// drive enables and data, registered grant, sampled pin data and status.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface avr_port_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   drive;
  logic [8*NREQ-1:0] dout;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        din;
  logic              busy;
  logic              timeout;

  // Requester side (stimulus / peripheral models)
  modport master (
    output req, drive, dout,
    input  gnt, din, busy, timeout
  );

  // Arbiter side
  modport slave (
    input  req, drive, dout,
    output gnt, din, busy, timeout
  );
endinterface

`default_nettype wire

// File: rtl/avr_port_arbiter.sv
// ============================================================================
// avr_port_arbiter
// Round-robin owner of one 8-bit bidirectional AVR port. Grants one requester
// at a time, drives or tri-states the pins for it, inserts a turnaround gap
// between owners and revokes a grant after HOLD_MAX cycles (0 = never).
// Revision: 1.0
// ============================================================================
`default_nettype none

module avr_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int HOLD_MAX   = 16,
  parameter int TURNAROUND = 1
) (
  input  wire              clk,
  input  wire              rst,
  avr_port_arbiter_if.slave port,
  // The pins stay a plain inout so the tristate net resolves at the top level.
  inout  wire [7:0]        bus
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [3:0]    TURN_INIT = 4'(TURNAROUND - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      turn_q, turn_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      din_q;

  logic [NREQ-1:0][7:0] dout_a;
  logic                 pick_found;
  logic [OW-1:0]        pick_idx;
  logic                 limit_hit;
  logic                 drive_en;

  assign dout_a = port.dout;

  // Round-robin search: first set request starting at ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!pick_found && port.req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  assign limit_hit = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);

  // Next-state, grant and pointer logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          hold_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        hold_d = hold_q + 1'b1;
        if (!port.req[owner_q] || limit_hit) begin
          state_d   = S_TURN;
          gnt_d     = '0;
          ptr_d     = OW'((int'(owner_q) + 1) % NREQ);
          turn_d    = TURN_INIT;
          // A release that coincides with the limit is a normal release.
          timeout_d = limit_hit && port.req[owner_q];
        end
      end
      S_TURN: begin
        gnt_d = '0;
        if (turn_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers plus the pin sample; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      din_q     <= bus;
    end
  end

  // Owner's drive enable acts in the same cycle; everyone else is ignored.
  assign drive_en = (state_q == S_GRANT) && port.drive[owner_q];
  assign bus      = drive_en ? dout_a[owner_q] : 8'bzzzz_zzzz;

  assign port.gnt     = gnt_q;
  assign port.din     = din_q;
  assign port.busy    = (state_q != S_IDLE);
  assign port.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_avr_port_arbiter.sv
// ============================================================================
// tb_avr_port_arbiter
// Directed bench for avr_port_arbiter: three instances cover the default hold
// limit, a short hold limit (rotation) and an unlimited hold with a long
// turnaround. Released pins are pulled low so a tri-stated bus reads 8'h00.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_avr_port_arbiter;

  logic clk;
  logic rst;
  logic ext_en;
  logic [7:0] ext_val;

  wire [7:0] b0;
  wire [7:0] b1;
  wire [7:0] b2;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] sb[$];

  avr_port_arbiter_if #(.NREQ(4)) if0 ();
  avr_port_arbiter_if #(.NREQ(4)) if1 ();
  avr_port_arbiter_if #(.NREQ(4)) if2 ();

  assign b0 = ext_en ? ext_val : 8'bzzzz_zzzz;

  for (genvar i = 0; i < 8; i++) begin : g_pd
    pulldown (b0[i]);
    pulldown (b1[i]);
    pulldown (b2[i]);
  end

  avr_port_arbiter #(.NREQ(4), .HOLD_MAX(16), .TURNAROUND(1)) u0 (
    .clk(clk), .rst(rst), .port(if0), .bus(b0));
  avr_port_arbiter #(.NREQ(4), .HOLD_MAX(4), .TURNAROUND(1)) u1 (
    .clk(clk), .rst(rst), .port(if1), .bus(b1));
  avr_port_arbiter #(.NREQ(4), .HOLD_MAX(0), .TURNAROUND(3)) u2 (
    .clk(clk), .rst(rst), .port(if2), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int len;
    int held;
    int tos;
    logic [31:0] e;

    rst = 1'b1; ext_en = 1'b0; ext_val = 8'h00;
    if0.req = '0; if0.drive = '0; if0.dout = '0;
    if1.req = '0; if1.drive = '0; if1.dout = '0;
    if2.req = '0; if2.drive = '0; if2.dout = '0;
    tick(); tick();

    // Reset state
    chk("rst_gnt0", 32'(if0.gnt), 32'h0);
    chk("rst_din0", 32'(if0.din), 32'h0);
    chk("rst_busy0", 32'(if0.busy), 32'h0);
    chk("rst_timeout0", 32'(if0.timeout), 32'h0);
    chk("rst_bus0", 32'(b0), 32'h0);
    chk("rst_gnt1", 32'(if1.gnt), 32'h0);
    rst = 1'b0;
    tick();

    // Single requester 2 drives A5 for five grant cycles
    if0.req = 4'b0100; if0.drive = 4'b0100; if0.dout[23:16] = 8'hA5;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("single_gnt", 32'(if0.gnt), 32'h4);
      chk("single_bus", 32'(b0), 32'hA5);
      chk("single_busy", 32'(if0.busy), 32'h1);
      sb.push_back(32'hA5);
      if (i == 4) if0.req = 4'b0000;
      tick();
      e = sb.pop_front();
      chk("single_din", 32'(if0.din), e);
    end
    chk("single_rel_gnt", 32'(if0.gnt), 32'h0);
    chk("single_rel_bus", 32'(b0), 32'h0);
    chk("single_turn_busy", 32'(if0.busy), 32'h1);
    chk("single_no_timeout", 32'(if0.timeout), 32'h0);
    sb.push_back(32'h0);
    tick();
    e = sb.pop_front();
    chk("single_din_z", 32'(if0.din), e);
    chk("single_idle_busy", 32'(if0.busy), 32'h0);

    // Reset mid-grant while driving FF (ptr is 3 at this point)
    if0.req = 4'b0001; if0.drive = 4'b0001; if0.dout[7:0] = 8'hFF;
    tick();
    chk("rstmid_gnt", 32'(if0.gnt), 32'h1);
    chk("rstmid_bus", 32'(b0), 32'hFF);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_gnt_async", 32'(if0.gnt), 32'h0);
    chk("rstmid_bus_async", 32'(b0), 32'h0);
    chk("rstmid_busy_async", 32'(if0.busy), 32'h0);
    tick();
    rst = 1'b0;
    if0.req = 4'b1001; if0.drive = 4'b0000;
    tick();
    chk("rstmid_ptr0_gnt", 32'(if0.gnt), 32'h1);
    if0.req = 4'b0000;
    tick(); tick();

    // Read mode: requester 3 reads while an external driver puts 3C on the pins
    if0.req = 4'b1000; if0.drive = 4'b0000; if0.dout[31:24] = 8'hEE;
    ext_en = 1'b1; ext_val = 8'h3C;
    tick();
    chk("read_gnt", 32'(if0.gnt), 32'h8);
    chk("read_bus", 32'(b0), 32'h3C);
    sb.push_back(32'h3C);
    tick();
    e = sb.pop_front();
    chk("read_din", 32'(if0.din), e);
    chk("read_bus_hold", 32'(b0), 32'h3C);
    // Mid-grant drive toggle takes effect immediately
    if0.drive = 4'b1000; ext_en = 1'b0;
    #1;
    chk("read_toggle_bus", 32'(b0), 32'hEE);
    if0.req = 4'b0000; if0.drive = 4'b0000;
    tick(); tick();

    // Rotation with HOLD_MAX=4: grants 0,1,2,3,0 of 4 cycles, 2-cycle gaps
    for (int g = 0; g < 4; g++) sb.push_back(32'(g));
    sb.push_back(32'h0);
    if1.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (if1.gnt == 4'b0000 && w < 10) begin
        tick();
        w++;
      end
      chk("rot_gap", 32'(w), (g == 0) ? 32'd1 : 32'd2);
      e = sb.pop_front();
      chk("rot_owner", 32'(if1.gnt), 32'h1 << e);
      chk("rot_timeout_low", 32'(if1.timeout), 32'h0);
      len = 0;
      while (if1.gnt != 4'b0000 && len < 20) begin
        len++;
        tick();
      end
      chk("rot_len", 32'(len), 32'd4);
      chk("rot_timeout_pulse", 32'(if1.timeout), 32'h1);
    end
    if1.req = 4'b0000;
    tick();
    chk("rot_timeout_one_cycle", 32'(if1.timeout), 32'h0);

    // HOLD_MAX=0: requester 1 keeps the bus for 100 cycles, no timeout
    if2.req = 4'b0010;
    tick();
    held = 0;
    tos = 0;
    repeat (100) begin
      if (if2.gnt == 4'b0010) held++;
      if (if2.timeout) tos++;
      tick();
    end
    chk("nolimit_held", 32'(held), 32'd100);
    chk("nolimit_timeouts", 32'(tos), 32'd0);

    // TURNAROUND=3: gnt[1] rises exactly 4 cycles after gnt[0] falls
    if2.req = 4'b0000;
    repeat (5) tick();
    if2.req = 4'b0011;
    tick();
    chk("turn_first_owner", 32'(if2.gnt), 32'h1);
    tick(); tick();
    if2.req = 4'b0010;
    tick();
    chk("turn_release", 32'(if2.gnt), 32'h0);
    w = 0;
    while (if2.gnt == 4'b0000 && w < 20) begin
      tick();
      w++;
    end
    chk("turn_gap", 32'(w), 32'd4);
    chk("turn_next_owner", 32'(if2.gnt), 32'h2);
    if2.req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
